// File: rtl/ahb_copy_dma.sv
// ahb_copy_dma: AHB-Lite master copying a block of 32-bit words, reads and writes overlapped in the pipeline.
// Ports:
//   i_clk, i_res_n            clock, asynchronous active-low reset
//   i_start, i_src_addr,      copy request (sampled only while idle), byte addresses
//   i_dst_addr, i_len         with bits [1:0] ignored, word count
//   o_busy, o_done, o_err     status: copy active, end-of-copy pulse, sticky error
//   o_m_h*                    AHB-Lite master address/control/write-data outputs
//   i_m_hready, i_m_hrdata,   AHB-Lite slave response
//   i_m_hresp
module ahb_copy_dma #(
    parameter int LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_res_n,
    input  logic             i_start,
    input  logic [31:0]      i_src_addr,
    input  logic [31:0]      i_dst_addr,
    input  logic [LEN_W-1:0] i_len,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err,
    output logic [1:0]       o_m_htrans,
    output logic             o_m_hwrite,
    output logic [31:0]      o_m_haddr,
    output logic [31:0]      o_m_hwdata,
    output logic [2:0]       o_m_hsize,
    output logic [2:0]       o_m_hburst,
    output logic [3:0]       o_m_hprot,
    output logic             o_m_hmastlock,
    input  logic             i_m_hready,
    input  logic [31:0]      i_m_hrdata,
    input  logic             i_m_hresp
);
    typedef enum logic [2:0] {S_IDLE, S_RADDR, S_WADDR, S_WDATA, S_FIN, S_ERRW} state_t;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] NONSEQ = 2'b10;
    state_t           r_state;
    logic [29:0]      r_src;
    logic [29:0]      r_dst;
    logic [LEN_W-1:0] r_cnt;
    logic [31:0]      r_buf;
    logic [1:0]       r_htrans;
    logic             r_hwrite;
    logic [29:0]      r_haddr;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             w_more;
    logic             w_bus_err;
    logic             w_unused;
    assign w_more = r_cnt > LEN_W'(1);
    // first cycle of a two-cycle error response on the data phase in flight
    assign w_bus_err = i_m_hresp && !i_m_hready;
    assign w_unused = ^{i_src_addr[1:0], i_dst_addr[1:0]};
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_err = r_err;
    assign o_m_htrans = r_htrans;
    assign o_m_hwrite = r_hwrite;
    assign o_m_haddr = {r_haddr, 2'b00};
    assign o_m_hwdata = r_buf;
    assign o_m_hsize = 3'b010;
    assign o_m_hburst = 3'b000;
    assign o_m_hprot = 4'b0011;
    assign o_m_hmastlock = 1'b0;
    // Bus outputs are registered: each transition loads the values the next state drives.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            r_state <= S_IDLE;
            r_src <= '0;
            r_dst <= '0;
            r_cnt <= '0;
            r_buf <= '0;
            r_htrans <= IDLE;
            r_hwrite <= 1'b0;
            r_haddr <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_src <= i_src_addr[31:2];
                    r_dst <= i_dst_addr[31:2];
                    r_cnt <= i_len;
                    r_err <= 1'b0;
                    if (i_len == '0) begin
                        r_state <= S_FIN;
                        r_done <= 1'b1;
                    end else begin
                        r_state <= S_RADDR;
                        r_busy <= 1'b1;
                        r_htrans <= NONSEQ;
                        r_hwrite <= 1'b0;
                        r_haddr <= i_src_addr[31:2];
                    end
                end
                S_RADDR: if (i_m_hready) begin
                    r_src <= r_src + 30'd1;
                    r_state <= S_WADDR;
                    r_hwrite <= 1'b1;
                    r_haddr <= r_dst;
                end
                S_WADDR: if (w_bus_err) begin
                    r_state <= S_ERRW;
                    r_htrans <= IDLE;
                end else if (i_m_hready) begin
                    r_buf <= i_m_hrdata;
                    r_dst <= r_dst + 30'd1;
                    r_state <= S_WDATA;
                    // next read's address phase overlaps this write's data phase
                    r_htrans <= w_more ? NONSEQ : IDLE;
                    if (w_more) begin
                        r_hwrite <= 1'b0;
                        r_haddr <= r_src;
                    end
                end
                S_WDATA: if (w_bus_err) begin
                    r_state <= S_ERRW;
                    r_htrans <= IDLE;
                end else if (i_m_hready) begin
                    r_cnt <= r_cnt - LEN_W'(1);
                    if (w_more) begin
                        r_src <= r_src + 30'd1;
                        r_state <= S_WADDR;
                        r_htrans <= NONSEQ;
                        r_hwrite <= 1'b1;
                        r_haddr <= r_dst;
                    end else begin
                        r_state <= S_FIN;
                        r_htrans <= IDLE;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                S_ERRW: if (i_m_hready) begin
                    r_err <= 1'b1;
                    r_state <= S_FIN;
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                S_FIN: begin
                    r_done <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_copy_dma.sv
// tb_ahb_copy_dma: scoreboard bench for ahb_copy_dma with an AHB memory slave (waits, error injection).
// Ports: none (top-level bench); drives the DUT copy port and models the AHB slave side.
module tb_ahb_copy_dma;
    logic        clk = 1'b0;
    logic        res_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src = '0;
    logic [31:0] dst = '0;
    logic [15:0] len_i = '0;
    logic        busy, done, err, hwrite;
    logic [1:0]  htrans;
    logic [31:0] haddr, hwdata, hrdata;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        hmastlock, hready, hresp;

    ahb_copy_dma #(.LEN_W(16)) dut (
        .i_clk(clk), .i_res_n(res_n), .i_start(start), .i_src_addr(src), .i_dst_addr(dst),
        .i_len(len_i), .o_busy(busy), .o_done(done), .o_err(err), .o_m_htrans(htrans),
        .o_m_hwrite(hwrite), .o_m_haddr(haddr), .o_m_hwdata(hwdata), .o_m_hsize(hsize),
        .o_m_hburst(hburst), .o_m_hprot(hprot), .o_m_hmastlock(hmastlock),
        .i_m_hready(hready), .i_m_hrdata(hrdata), .i_m_hresp(hresp)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int start_cyc = 0;
    int busy_cnt = 0;
    int busy_base = 0;
    int dones = 0;
    int rd_total = 0;
    int err_at = -1;
    bit wait_en = 1'b0;

    logic [31:0] smem  [logic [29:0]];
    logic [31:0] model [logic [29:0]];
    logic [31:0] rq[$];
    logic [63:0] wq[$];
    bit          dq_err[$];
    int          dq_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (!ok) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] sget(input logic [29:0] a);
        return smem.exists(a) ? smem[a] : 32'd0;
    endfunction

    function automatic logic [31:0] mget(input logic [29:0] a);
        return model.exists(a) ? model[a] : 32'd0;
    endfunction

    task automatic poke(input logic [29:0] a, input logic [31:0] d);
        smem[a] = d;
        model[a] = d;
    endtask

    // AHB memory slave: waits chosen by HADDR[3:2], two-cycle error on a chosen read
    logic        s_valid, s_write;
    logic [29:0] s_addr;
    logic [1:0]  s_wait, s_err;
    logic [31:0] s_rdata;
    assign hready = !(s_valid && (s_wait != 2'd0 || s_err == 2'd1));
    assign hresp = s_valid && s_wait == 2'd0 && s_err != 2'd0;
    assign hrdata = s_rdata;

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            s_valid <= 1'b0;
            s_write <= 1'b0;
            s_addr <= '0;
            s_wait <= '0;
            s_err <= '0;
            s_rdata <= '0;
        end else if (hready) begin
            if (s_valid && s_write && s_err == 2'd0) smem[s_addr] = hwdata;
            if (htrans == 2'b10) begin
                s_valid <= 1'b1;
                s_write <= hwrite;
                s_addr <= haddr[31:2];
                s_wait <= wait_en ? haddr[3:2] : 2'd0;
                s_err <= (!hwrite && rd_total == err_at) ? 2'd1 : 2'd0;
                s_rdata <= hwrite ? 32'd0 : sget(haddr[31:2]);
                if (!hwrite) rd_total <= rd_total + 1;
            end else s_valid <= 1'b0;
        end else if (s_wait != 2'd0) s_wait <= s_wait - 2'd1;
        else if (s_err == 2'd1) s_err <= 2'd2;
    end

    // monitor: pops expectations whenever the bus or status shows an event
    bit          p_valid = 1'b0, p_ready = 1'b1, p_resp = 1'b0;
    logic [66:0] p_bus = '0;
    logic [31:0] e_r;
    logic [63:0] e_w;
    bit          e_e;
    int          e_c;
    always @(negedge clk) begin
        if (!res_n) p_valid = 1'b0;
        else begin
            if (hready && htrans == 2'b10 && !hwrite) begin
                if (rq.size() == 0) check(0, "read_unexpected", haddr, 0);
                else begin
                    e_r = rq.pop_front();
                    check(haddr == e_r, "read_addr", haddr, e_r);
                end
            end
            if (s_valid && s_write && hready && !hresp) begin
                if (wq.size() == 0) check(0, "write_unexpected", {s_addr, 2'b00, hwdata}, 0);
                else begin
                    e_w = wq.pop_front();
                    check({s_addr, 2'b00, hwdata} == e_w, "write", {s_addr, 2'b00, hwdata}, e_w);
                end
            end
            if (p_valid && !p_ready) begin
                if (p_resp) check(htrans == 2'b00, "idle_after_err", htrans, 0);
                else check({htrans, hwrite, haddr, hwdata} == p_bus, "stall_stable", {htrans, hwrite, haddr, hwdata}, p_bus);
            end
            if (busy) busy_cnt++;
            if (done) begin
                if (dq_err.size() == 0) check(0, "done_unexpected", 1, 0);
                else begin
                    e_e = dq_err.pop_front();
                    e_c = dq_cyc.pop_front();
                    check({busy, err} == {1'b0, e_e}, "done_flags", {busy, err}, {1'b0, e_e});
                    if (e_c > 0) begin
                        check(cyc - start_cyc + 1 == e_c, "done_cycle", cyc - start_cyc + 1, e_c);
                        check(busy_cnt - busy_base == e_c - 1, "busy_cycles", busy_cnt - busy_base, e_c - 1);
                    end
                end
                dones++;
            end
            p_valid = 1'b1;
            p_ready = hready;
            p_resp = hresp;
            p_bus = {htrans, hwrite, haddr, hwdata};
        end
    end

    // reference model: sequential word-by-word copy; each read sees earlier writes
    task automatic issue_copy(input logic [31:0] sa, input logic [31:0] da, input int len,
                              input bit we, input int errk, input bit commit);
        logic [29:0] s, d, a;
        logic [31:0] v;
        bit          e;
        s = sa[31:2];
        d = da[31:2];
        e = errk >= 0 && errk < len;
        for (int i = 0; i < len; i++) begin
            a = s + 30'(i);
            rq.push_back({a, 2'b00});
            if (e && i == errk) break;
            v = mget(a);
            wq.push_back({d + 30'(i), 2'b00, v});
            if (commit) model[d + 30'(i)] = v;
        end
        dq_err.push_back(e);
        dq_cyc.push_back((we || e) ? 0 : (len == 0 ? 1 : 2 * len + 2));
        wait_en = we;
        err_at = e ? rd_total + errk : -1;
        @(negedge clk);
        start = 1'b1;
        src = sa;
        dst = da;
        len_i = 16'(len);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        busy_base = busy_cnt;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int d0 = dones;
        bit ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            ok = dones != d0;
        end
        if (!ok) check(0, "done_timeout", 0, 1);
        @(negedge clk);
        check(rq.size() == 0 && wq.size() == 0 && dq_err.size() == 0, "drained",
              rq.size() + wq.size() + dq_err.size(), 0);
    endtask

    task automatic copy(input logic [31:0] sa, input logic [31:0] da, input int len, input bit we, input int errk);
        issue_copy(sa, da, len, we, errk, 1'b1);
        wait_done();
    endtask

    task automatic chk_reset(input string nm);
        check({htrans, hwrite, haddr, hwdata, busy, done, err} == '0, nm,
              {htrans, hwrite, haddr, hwdata, busy, done, err}, 0);
    endtask

    initial begin
        bit ok;
        for (int a = 64; a < 192; a++) poke(30'(a), $urandom);
        repeat (3) @(negedge clk);
        chk_reset("reset_state");
        check({hsize, hburst, hprot, hmastlock} == {3'b010, 3'b000, 4'b0011, 1'b0}, "constants",
              {hsize, hburst, hprot, hmastlock}, {3'b010, 3'b000, 4'b0011, 1'b0});
        res_n = 1'b1;
        repeat (2) @(negedge clk);

        poke(30'h40, 32'hDEADBEEF);
        copy(32'h100, 32'h200, 1, 1'b0, -1);
        for (int k = 0; k < 4; k++) poke(30'h40 + 30'(k), 32'h11111111 * (k + 1));
        copy(32'h100, 32'h200, 4, 1'b0, -1);
        copy(32'h100, 32'h300, 8, 1'b1, -1);
        poke(30'h40, 32'hA);
        poke(30'h41, 32'hB);
        copy(32'h100, 32'h104, 2, 1'b0, -1);
        check(mget(30'h42) == 32'hA, "overlap_model", mget(30'h42), 32'hA);

        copy(32'h100, 32'h400, 3, 1'b0, 1);
        repeat (3) @(negedge clk);
        check(err == 1'b1, "err_sticky", err, 1);
        copy(32'h100, 32'h400, 0, 1'b0, -1);

        issue_copy(32'h180, 32'h700, 4, 1'b0, -1, 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = s_valid && s_write;
        end
        check(ok, "reach_wdata", ok, 1);
        res_n = 1'b0;
        #1;
        chk_reset("mid_copy_reset");
        rq.delete();
        wq.delete();
        dq_err.delete();
        dq_cyc.delete();
        @(negedge clk);
        res_n = 1'b1;
        copy(32'h180, 32'h700, 4, 1'b0, -1);

        poke(30'h3FFFFFFF, 32'hCAFEF00D);
        poke(30'h0, 32'h12345678);
        copy(32'hFFFFFFFC, 32'h500, 2, 1'b0, -1);

        for (int t = 0; t < 25; t++) begin
            logic [31:0] sa, da;
            int n, ek;
            sa = {22'd0, 8'($urandom_range(64, 191)), 2'($urandom)};
            da = {22'd0, 8'($urandom_range(64, 191)), 2'($urandom)};
            n = $urandom_range(0, 10);
            ek = ($urandom_range(0, 4) == 0 && n > 0) ? int'($urandom_range(0, n - 1)) : -1;
            copy(sa, da, n, 1'($urandom), ek);
        end

        foreach (model[a]) check(sget(a) == model[a], "mem", sget(a), model[a]);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/ahb_copy_dma.md
# ahb_copy_dma

AHB-Lite master that copies a block of 32-bit words from a source address to a destination address, one word at a time, with reads and writes overlapped in the AHB pipeline. It sits directly upstream of the on-chip RAM slave, through the bus matrix, as a second bus master alongside the CPU. Software or a controller block starts it through a simple start/length port set and sees BUSY, DONE and ERR.

## Interface
- LEN_W, 16, width of the word-count input.
- CLK  input  1  system clock, all state on rising edge.
- RES_N  input  1  asynchronous active-low reset.
- START  input  1  start request, sampled only while BUSY=0.
- SRC_ADDR  input  32  source byte address; bits [1:0] ignored and treated as 00.
- DST_ADDR  input  32  destination byte address; bits [1:0] ignored and treated as 00.
- LEN  input  LEN_W  number of words to copy.
- BUSY  output  1  high while a copy is in progress.
- DONE  output  1  one-cycle pulse at end of copy, whether the copy succeeds, fails or has zero length.
- ERR  output  1  sticky error flag, cleared by the next accepted START.
- M_HTRANS  output  2  only 00 (IDLE) or 10 (NONSEQ).
- M_HWRITE  output  1  transfer direction.
- M_HADDR  output  32  transfer address, always word-aligned.
- M_HWDATA  output  32  write data.
- M_HSIZE  output  3  constant 010.
- M_HBURST  output  3  constant 000.
- M_HPROT  output  4  constant 0011.
- M_HMASTLOCK  output  1  constant 0.
- M_HREADY  input  1  bus ready.
- M_HRDATA  input  32  read data.
- M_HRESP  input  1  error response.

## Operation
- Reset values: M_HTRANS=00, M_HWRITE=0, M_HADDR=0, M_HWDATA=0, BUSY=0, DONE=0, ERR=0. State is IDLE, and all internal registers are 0.
- Internal registers:
  - src: 30-bit word address.
  - dst: 30-bit word address.
  - cnt: LEN_W bits.
  - buf: 32 bits.
- Address arithmetic is modulo 2^32, so 0xFFFFFFFC+4 wraps to 0x00000000.
- The copy is forward and ascending. With overlapping regions, each read sees all writes completed before it; this follows from the AHB pipeline order.
- IDLE:
  - START=1 loads src, dst and cnt, and clears ERR.
  - If LEN=0, go to FIN; otherwise go to RADDR.
- RADDR:
  - Drive NONSEQ, HWRITE=0, HADDR=src.
  - When M_HREADY=1: src+=1, go to WADDR.
- WADDR (read data phase plus write address phase):
  - Drive NONSEQ, HWRITE=1, HADDR=dst.
  - When M_HREADY=1: buf<=M_HRDATA, dst+=1, go to WDATA.
- WDATA (write data phase):
  - Drive M_HWDATA=buf.
  - If cnt>1, also drive NONSEQ read with HADDR=src; otherwise drive HTRANS=IDLE.
  - When M_HREADY=1: cnt-=1. If the old cnt>1, src+=1 and go to WADDR; otherwise go to FIN.
- FIN: DONE=1 for one cycle, then go to IDLE.
- ERRW:
  - Drive HTRANS=IDLE.
  - When M_HREADY=1: set ERR=1 and go to FIN.
  - No further transfers are issued.
- Error entry: M_HRESP=1 with M_HREADY=0 in any data phase (WADDR or WDATA) sends the block to ERRW on the next cycle. The pending address phase is replaced by IDLE, as AHB-Lite permits. buf, src, dst and cnt are not updated.
- M_HWDATA holds buf outside WDATA. M_HADDR and M_HWRITE hold their last values when HTRANS=IDLE.
- BUSY=1 in RADDR, WADDR, WDATA and ERRW, and 0 in IDLE and FIN.
- START while BUSY=1 is ignored. START during FIN is ignored; it is accepted on the following IDLE cycle.
- Reset mid-copy: all outputs return to their reset values immediately, even if a bus transfer is in flight. No DONE pulse is produced.

## Timing
- Zero-wait copy of N≥1 words:
  - START accepted at edge 0.
  - RADDR occupies cycle 1.
  - WADDR and WDATA alternate for 2N cycles.
  - FIN (DONE=1) occurs in cycle 2N+2.
  - BUSY is high for 2N+1 cycles.
  - Throughput is 2 cycles per word.
- Each wait state from the slave, with M_HREADY=0, stalls the current state by exactly one cycle. All outputs stay stable while stalled.
- LEN=0: DONE pulses in the cycle after START, with no bus transfers.
- Two-cycle error response: ERR is visible in the cycle when FIN is entered and stays high until the next START.

## Test plan
- Single-word copy:
  - Stimulus: RAM preloaded so that [0x100]=0xDEADBEEF; LEN=1, SRC=0x100, DST=0x200.
  - Required: [0x200]=0xDEADBEEF; DONE pulses in cycle 4; BUSY is high for 3 cycles; bus sequence is R0x100, W0x200, IDLE.
- Zero-wait four-word copy into the RAM:
  - Stimulus: [0x100..0x10C]=0x11111111..0x44444444; LEN=4, DST=0x200.
  - Required: destination matches source; DONE pulses at cycle 10.
- Wait-state copy:
  - Stimulus: RAM built with HAVE_RAM_WAIT (0-3 waits, set by HADDR[3:2]); copy 0x100→0x300, LEN=8.
  - Required: data is correct; M_HADDR, M_HWRITE and M_HWDATA are stable during every M_HREADY=0 cycle.
- Overlap forwarding:
  - Stimulus: [0x100]=0xA, [0x104]=0xB; copy SRC=0x100 to DST=0x104, LEN=2.
  - Required: [0x104]=0xA and [0x108]=0xA. This exercises the RAM read-during-write forwarding.
- Error and zero length:
  - Stimulus: slave model returns HRESP on the second read.
  - Required: HTRANS=IDLE the next cycle; ERR=1; DONE pulses; only one word is written.
  - Then START with LEN=0 clears ERR; DONE pulses 1 cycle later with no transfers.
- Reset and wrap:
  - Reset: assert RES_N=0 during WDATA; all outputs go to reset values immediately; a new copy afterwards is correct.
  - Wrap: SRC=0xFFFFFFFC with LEN=2 reads 0xFFFFFFFC and then 0x00000000.
